multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
- Multicycle control unit that produces the unconditioned control signals PCS, RegW, MemW and FlagW.
- These outputs feed the existing condition-check block, which gates them with CondEx.
- A Moore main FSM sequences every instruction through fetch/decode/execute/writeback.
- An ALU decoder produces ALUControl and FlagW from the instruction's Funct field.

Parameters:
STATE_W, 4, width of state register and debug state port (minimum 4).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high; forces FSM to FETCH.
Instr  input  32  instruction-register contents (stable after FETCH).
IRWrite  output  1  load instruction register.
NextPC  output  1  unconditional PC update (PC+4).
AdrSrc  output  1  memory address select (0 = PC, 1 = ALU result register).
ALUSrcA  output  2  ALU A select (00 = register A, 01 = PC).
ALUSrcB  output  2  ALU B select (00 = register B, 01 = ExtImm, 10 = constant 4).
ALUControl  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
ResultSrc  output  2  result mux select (00 = ALUOut, 01 = Data, 10 = ALU direct).
FlagW  output  2  [1] = write N,Z; [0] = write C,V (unconditioned).
PCS  output  1  PC write from branch or Rd==15 writeback (unconditioned).
RegW  output  1  register-file write (unconditioned).
MemW  output  1  memory write (unconditioned).
State  output  STATE_W  current state, debug only.

Behaviour:
- Fields: Op = Instr[27:26], Funct = Instr[25:20], cmd = Funct[4:1], S/L = Funct[0], Rd = Instr[15:12].
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
- Unused encodings go to FETCH on the next edge; all outputs are 0 in unused encodings.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR, Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (illegal, no side effects).
  - MEMADR: L=1 -> MEMRD, L=0 -> MEMWR.
  - MEMRD -> MEMWB. MEMWB, MEMWR, ALUWB, BRANCH -> FETCH. EXECR/EXECI -> ALUWB.
- Cycle counts: LDR 5, STR 4, DP 4, B 3, illegal 2.
- Outputs are Moore, from state only. Any signal not listed below is 0.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0 (precomputes PC+8).
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1. MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1. EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00; RegW=1 except cmd=1010 (CMP), which gives RegW=0.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decoder:
  - ALUOp=0 -> ALUControl=00, FlagW=00.
  - ALUOp=1 -> cmd 0100 -> 00; 0010 -> 01; 0000 -> 10; 1100 -> 11; 1010 -> 01; other cmd -> 00 with FlagW=00.
  - FlagW[1] = S. FlagW[0] = S and ALUControl is ADD or SUB.
- PCS = Branch | (RegW & Rd==15). PCS is combinational from state and Instr.
- Reset:
  - Asynchronous assert: state=FETCH immediately.
  - While reset=1, all outputs are 0: IRWrite, NextPC, PCS, RegW, MemW and FlagW are forced low. Mux selects are also 0.
  - First FETCH outputs appear the cycle after deassertion.
  - Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- Instr is assumed stable from DECODE onward. A changing Instr in DECODE selects the branch target per that cycle's value only.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings
  - Op codes (DP=00, MEM=01, BR=10)
  - cmd codes (AND, SUB, ADD, CMP, ORR)
  - ALUControl codes and mux-select constants
- One sub-module, alu_decode (combinational: ALUOp, Funct -> ALUControl, FlagW).
- The FSM register and next-state/output logic stay in multicycle_main_controller.

Test Plan:
- Reset held 3 cycles, released, Instr=0xE0821003 (ADD R1,R2,R3) -> all outputs 0 during reset. Then State 0,1,6,8,0; RegW=1 only in ALUWB; ALUControl=00 in EXECR; FlagW=00; PCS=0.
- Instr=0xE5910004 (LDR R0,[R1,#4]) -> States 0,1,2,3,4,0. AdrSrc=1 in MEMRD. ResultSrc=01 with RegW=1 in MEMWB; MemW never 1.
- Instr=0xE5810004 (STR) -> States 0,1,2,5,0; MemW=1 only in MEMWR; RegW never 1.
- Instr=0xE3510005 (CMP R1,#5) -> EXECI with ALUControl=01, FlagW=11; ALUWB RegW=0. Then Instr=0xE0121003 (ANDS) -> ALUControl=10, FlagW=10.
- Instr=0xEA000002 (B) -> States 0,1,9,0; PCS=1 and Branch=1 in BRANCH. Instr=0xE08FF003 (ADD PC) -> PCS=1 in ALUWB only.
- Instr Op=11 -> States 0,1,0, no write enables. Reset asserted in MEMWR -> MemW drops the same cycle, State=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: FSM states, opcode/cmd
// fields, ALU operation codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_ORR = 2'b11;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decode.sv
// ALU decoder: maps the data-processing cmd/S bits to an ALU operation and the
// unconditioned flag-write enables.
module alu_decode
    import ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [5:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
);

    logic known_cmd;
    logic funct_unused;

    // Funct[5] (immediate select) only steers the FSM, not the ALU.
    assign funct_unused = Funct[5];

    always_comb begin
        ALUControl = ALUC_ADD;
        FlagW      = 2'b00;
        known_cmd  = 1'b0;
        if (ALUOp) begin
            known_cmd = 1'b1;
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALUC_ADD;
                CMD_SUB: ALUControl = ALUC_SUB;
                CMD_AND: ALUControl = ALUC_AND;
                CMD_ORR: ALUControl = ALUC_ORR;
                CMD_CMP: ALUControl = ALUC_SUB;
                default: begin
                    ALUControl = ALUC_ADD;
                    known_cmd  = 1'b0;
                end
            endcase
            if (known_cmd) begin
                FlagW[1] = Funct[0];
                FlagW[0] = Funct[0] &
                           ((ALUControl == ALUC_ADD) || (ALUControl == ALUC_SUB));
            end
        end
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Moore main FSM for the multicycle processor. Write enables are unconditioned;
// the downstream condition-check block gates them with CondEx.
module multicycle_main_controller
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Instr,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         FlagW,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [STATE_W-1:0] State
);

    state_e     state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       instr_unused;

    logic       irwrite_c, nextpc_c, adrsrc_c, aluop_c, branch_c, regw_c, memw_c;
    logic [1:0] alusrca_c, alusrcb_c, resultsrc_c;
    logic [1:0] alucontrol_c, flagw_c;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign instr_unused = ^{Instr[31:28], Instr[19:16], Instr[11:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        irwrite_c   = 1'b0;
        nextpc_c    = 1'b0;
        adrsrc_c    = 1'b0;
        alusrca_c   = SRCA_REG;
        alusrcb_c   = SRCB_REG;
        resultsrc_c = RES_ALUOUT;
        aluop_c     = 1'b0;
        branch_c    = 1'b0;
        regw_c      = 1'b0;
        memw_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d     = S_DECODE;
                irwrite_c   = 1'b1;
                nextpc_c    = 1'b1;
                alusrca_c   = SRCA_PC;
                alusrcb_c   = SRCB_FOUR;
                resultsrc_c = RES_ALU;
            end
            S_DECODE: begin
                // Second PC+4 yields PC+8, the architectural PC read value.
                alusrca_c   = SRCA_PC;
                alusrcb_c   = SRCB_FOUR;
                resultsrc_c = RES_ALU;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
                alusrcb_c = SRCB_IMM;
            end
            S_MEMRD: begin
                state_d  = S_MEMWB;
                adrsrc_c = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_c = RES_DATA;
                regw_c      = 1'b1;
            end
            S_MEMWR: begin
                adrsrc_c = 1'b1;
                memw_c   = 1'b1;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
                aluop_c = 1'b1;
            end
            S_EXECI: begin
                state_d   = S_ALUWB;
                alusrcb_c = SRCB_IMM;
                aluop_c   = 1'b1;
            end
            S_ALUWB: begin
                regw_c = (funct[4:1] != CMD_CMP);
            end
            S_BRANCH: begin
                alusrcb_c   = SRCB_IMM;
                resultsrc_c = RES_ALU;
                branch_c    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decode u_alu_decode (
        .ALUOp      (aluop_c),
        .Funct      (funct),
        .ALUControl (alucontrol_c),
        .FlagW      (flagw_c)
    );

    // Everything is held low while reset is asserted, including mux selects.
    always_comb begin
        IRWrite    = ~reset & irwrite_c;
        NextPC     = ~reset & nextpc_c;
        AdrSrc     = ~reset & adrsrc_c;
        ALUSrcA    = reset ? 2'b00 : alusrca_c;
        ALUSrcB    = reset ? 2'b00 : alusrcb_c;
        ALUControl = reset ? 2'b00 : alucontrol_c;
        ResultSrc  = reset ? 2'b00 : resultsrc_c;
        FlagW      = reset ? 2'b00 : flagw_c;
        RegW       = ~reset & regw_c;
        MemW       = ~reset & memw_c;
        PCS        = ~reset & (branch_c | (regw_c & (rd == 4'd15)));
        State      = '0;
        State[3:0] = reset ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: walks each instruction class
// through its state sequence and compares every output per cycle.
module tb_multicycle_main_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'hE0821003;
    logic        IRWrite, NextPC, AdrSrc, PCS, RegW, MemW;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, FlagW;
    logic [3:0]  State;
    logic [15:0] outv;

    int checks = 0;
    int failures = 0;

    multicycle_main_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .State      (State)
    );

    always #5 clk = ~clk;

    assign outv = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUControl,
                   ResultSrc, FlagW, PCS, RegW, MemW};

    // Packed outputs: {IRWrite,NextPC,AdrSrc,SrcA[2],SrcB[2],ALUC[2],Res[2],FlagW[2],PCS,RegW,MemW}
    localparam logic [15:0] V_ZERO    = 16'h0000;
    localparam logic [15:0] V_FETCH   = 16'hCC40;
    localparam logic [15:0] V_DECODE  = 16'h0C40;
    localparam logic [15:0] V_MEMADR  = 16'h0200;
    localparam logic [15:0] V_MEMRD   = 16'h2000;
    localparam logic [15:0] V_MEMWB   = 16'h0022;
    localparam logic [15:0] V_MEMWR   = 16'h2001;
    localparam logic [15:0] V_EXEC_AD = 16'h0000;
    localparam logic [15:0] V_EXEC_CP = 16'h0298;
    localparam logic [15:0] V_EXEC_AN = 16'h0110;
    localparam logic [15:0] V_ALUWB   = 16'h0002;
    localparam logic [15:0] V_ALUWB_P = 16'h0006;
    localparam logic [15:0] V_BRANCH  = 16'h0244;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] es, input logic [15:0] ev);
        @(negedge clk);
        check({tag, "_state"}, {28'd0, State}, {28'd0, es});
        check({tag, "_outs"}, {16'd0, outv}, {16'd0, ev});
    endtask

    initial begin
        // Reset held three cycles: everything low.
        for (int i = 0; i < 3; i++) cyc("reset", 4'd0, V_ZERO);
        @(posedge clk);
        #1 reset = 1'b0;

        // ADD R1,R2,R3
        cyc("add_f", 4'd0, V_FETCH);
        cyc("add_d", 4'd1, V_DECODE);
        cyc("add_x", 4'd6, V_EXEC_AD);
        cyc("add_wb", 4'd8, V_ALUWB);

        // LDR R0,[R1,#4]
        Instr = 32'hE5910004;
        cyc("ldr_f", 4'd0, V_FETCH);
        cyc("ldr_d", 4'd1, V_DECODE);
        cyc("ldr_a", 4'd2, V_MEMADR);
        cyc("ldr_r", 4'd3, V_MEMRD);
        cyc("ldr_wb", 4'd4, V_MEMWB);

        // STR R0,[R1,#4]
        Instr = 32'hE5810004;
        cyc("str_f", 4'd0, V_FETCH);
        cyc("str_d", 4'd1, V_DECODE);
        cyc("str_a", 4'd2, V_MEMADR);
        cyc("str_w", 4'd5, V_MEMWR);

        // CMP R1,#5
        Instr = 32'hE3510005;
        cyc("cmp_f", 4'd0, V_FETCH);
        cyc("cmp_d", 4'd1, V_DECODE);
        cyc("cmp_x", 4'd7, V_EXEC_CP);
        cyc("cmp_wb", 4'd8, V_ZERO);

        // ANDS R1,R2,R3
        Instr = 32'hE0121003;
        cyc("ands_f", 4'd0, V_FETCH);
        cyc("ands_d", 4'd1, V_DECODE);
        cyc("ands_x", 4'd6, V_EXEC_AN);
        cyc("ands_wb", 4'd8, V_ALUWB);

        // B
        Instr = 32'hEA000002;
        cyc("b_f", 4'd0, V_FETCH);
        cyc("b_d", 4'd1, V_DECODE);
        cyc("b_br", 4'd9, V_BRANCH);

        // ADD PC,PC,R3
        Instr = 32'hE08FF003;
        cyc("addpc_f", 4'd0, V_FETCH);
        cyc("addpc_d", 4'd1, V_DECODE);
        cyc("addpc_x", 4'd6, V_EXEC_AD);
        cyc("addpc_wb", 4'd8, V_ALUWB_P);

        // Op=11: illegal, straight back to FETCH
        Instr = 32'hEC000000;
        cyc("ill_f", 4'd0, V_FETCH);
        cyc("ill_d", 4'd1, V_DECODE);
        cyc("ill_f2", 4'd0, V_FETCH);

        // STR interrupted by reset in MEMWR
        Instr = 32'hE5810004;
        cyc("strr_d", 4'd1, V_DECODE);
        cyc("strr_a", 4'd2, V_MEMADR);
        cyc("strr_w", 4'd5, V_MEMWR);
        #1 reset = 1'b1;
        #1;
        check("rst_async_state", {28'd0, State}, 32'd0);
        check("rst_async_outs", {16'd0, outv}, {16'd0, V_ZERO});
        check("rst_async_memw", {31'd0, MemW}, 32'd0);
        cyc("rst_hold", 4'd0, V_ZERO);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("post_f", 4'd0, V_FETCH);
        cyc("post_d", 4'd1, V_DECODE);
        cyc("post_a", 4'd2, V_MEMADR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
